lc2k_multicycle_ctrl: RTL and testbench
=======================================

Name: lc2k_multicycle_ctrl

Overview:
Multi-cycle LC2K control and datapath sequencer that sits directly upstream of the register file. It fetches instructions over a ready-handshake memory port, decodes LC2K fields and drives the register file's read_regA/read_regB/write_reg/write_value/CONTROL_ENABLE_REG_WRITE. It consumes aluValA/regBvalue back, performs ALU, branch and PC update, and stops on halt.

Parameters:
ADDR_W, 16, PC and memory address width; all address arithmetic wraps modulo 2^ADDR_W

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
mem_req  out  1  memory request, fetch or data
mem_we  out  1  1 = store (sw)
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  store data
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  transaction completes in this cycle
read_regA  out  3  register file port A select
read_regB  out  3  register file port B select
aluValA  in  32  regfile value of read_regA, combinational
regBvalue  in  32  regfile value of read_regB, combinational
write_reg  out  3  writeback register
write_value  out  32  writeback data
CONTROL_ENABLE_REG_WRITE  out  1  one-cycle write strobe
halted  out  1  sticky, set on halt

Behaviour:
- Encoding: opcode[24:22] (add 0, nor 1, lw 2, sw 3, beq 4, jalr 5, halt 6, noop 7); regA[21:19]; regB[18:16]; destReg[2:0]; offset[15:0], sign-extended to 32.
- Single clock, synchronous active-high reset. Reset: state=FETCH, PC=0, IR=0, ALUOut=0, MDR=0, halted=0, all outputs 0. mem_req is forced 0 during the reset cycle.
- Reset mid-transaction abandons it; no write strobe issues.
- States:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. When mem_ready=1, IR<=mem_rdata, go to DECODE.
  - DECODE: read_regA=IR.regA, read_regB=IR.regB, held from here through WB. PC<=PC+1. halt goes to HALT; all other opcodes go to EXEC.
  - EXEC:
    - add/nor: ALUOut<=aluValA+regBvalue or ~(aluValA|regBvalue); go to WB.
    - lw/sw: ALUOut<=aluValA+sext(offset); go to MEM.
    - beq: if equal, PC<=PC+sext(offset); go to FETCH.
    - jalr: ALUOut<=PC (already +1), TGT<=aluValA[ADDR_W-1:0]; go to WB.
    - noop: go to FETCH.
  - MEM: mem_req=1, mem_addr=ALUOut[ADDR_W-1:0], mem_we=(sw), mem_wdata=regBvalue. When mem_ready=1: lw latches MDR and goes to WB; sw goes to FETCH.
  - WB: CONTROL_ENABLE_REG_WRITE=1 for exactly this cycle. write_reg is destReg for add/nor and regB for lw/jalr. write_value is ALUOut, or MDR for lw. Both are stable through the cycle and return to 0 next cycle. jalr also does PC<=TGT. Go to FETCH.
  - HALT: halted=1; mem_req=0 forever until reset.
- jalr with regA==regB: target is the pre-write regA value, captured in TGT during EXEC.
- Writes to r0 are permitted (no hardwired zero).
- mem_req/addr/we/wdata are held stable while mem_ready=0 (unbounded wait). mem_ready is ignored outside FETCH/MEM.
- Zero-wait cycle counts: add/nor 4, lw 5, sw 4, beq 3, jalr 4, noop 3, halt 2 to halted=1.

Optional Feature:
LC2K_PERF_CNT_EN:
- Defined: adds output retired_count[31:0]. Reset 0; increments once per instruction on its final state's exit (halt counts on entry to HALT). Wraps at 2^32.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package lc2k_pkg: opcode enum, state enum, field bit-position constants, OFFSET_W=16, sign-extend function.
- Sub-module lc2k_alu: combinational add/nor/equality.

Test Plan:
- add 1 2 3 (0x000A0003), regfile model r1=5, r2=3, zero-wait -> cycle 4: write_reg=3, write_value=8, strobe 1 for one cycle; next mem_addr=1.
- nor 1 2 4 (0x004A0004), r1=0xFFFF0000, r2=0x0000FF00 -> write_reg=4, write_value=0x000000FF.
- lw 0 1 -1 (0x0081FFFF), r0=0, mem_ready delayed 2 cycles with rdata=0x12345678 -> MEM mem_addr=0xFFFF held 3 cycles; write r1=0x12345678; no strobe before ready.
- beq 0 0 -2 (0x0100FFFE) at PC 5 -> next fetch addr 4, no strobe. sw 0 2 9 -> mem_we=1, addr 9, wdata=r2.
- jalr 3 3 (0x015B0000) at PC 7, r3=0x20 -> write r3=8; next fetch addr 0x20.
- halt (0x01800000) -> halted=1, mem_req stays 0. Assert reset mid-lw wait -> no strobe; first post-reset fetch at addr 0 with halted=0.

Source files
------------

// File: rtl/lc2k_pkg.sv
// Shared LC2K types and instruction field layout for the multi-cycle controller.
package lc2k_pkg;

    typedef enum logic [2:0] {
        OpAdd  = 3'd0,
        OpNor  = 3'd1,
        OpLw   = 3'd2,
        OpSw   = 3'd3,
        OpBeq  = 3'd4,
        OpJalr = 3'd5,
        OpHalt = 3'd6,
        OpNoop = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    localparam int unsigned OPCODE_LSB = 22;
    localparam int unsigned REGA_LSB   = 19;
    localparam int unsigned REGB_LSB   = 16;
    localparam int unsigned DEST_LSB   = 0;
    localparam int unsigned OFFSET_LSB = 0;
    localparam int unsigned OFFSET_W   = 16;
    localparam int unsigned REG_W      = 3;

    function automatic logic [31:0] sext_offset(input logic [OFFSET_W-1:0] off);
        return {{(32 - OFFSET_W){off[OFFSET_W-1]}}, off};
    endfunction

endpackage

// File: rtl/lc2k_alu.sv
// Combinational LC2K ALU: sum, bitwise nor and equality of two 32-bit operands.
module lc2k_alu (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o,
    output logic [31:0] nor_o,
    output logic        eq_o
);

    assign sum_o = a_i + b_i;
    assign nor_o = ~(a_i | b_i);
    assign eq_o  = (a_i == b_i);

endmodule

// File: rtl/lc2k_multicycle_ctrl.sv
// Multi-cycle LC2K sequencer driving an external register file and a ready-handshake memory.
// Optional macro LC2K_PERF_CNT_EN adds a retired-instruction counter output.
module lc2k_multicycle_ctrl
    import lc2k_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [2:0]        read_regA,
    output logic [2:0]        read_regB,
    input  logic [31:0]       aluValA,
    input  logic [31:0]       regBvalue,
    output logic [2:0]        write_reg,
    output logic [31:0]       write_value,
    output logic              CONTROL_ENABLE_REG_WRITE,
    output logic              halted
`ifdef LC2K_PERF_CNT_EN
    ,
    output logic [31:0]       retired_count
`endif
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;
    logic [31:0]       ir_q, ir_d;
    logic [31:0]       alu_out_q, alu_out_d;
    logic [31:0]       mdr_q, mdr_d;

    opcode_e           op;
    logic [REG_W-1:0]  reg_a, reg_b, dest;
    logic [31:0]       offset_ext;
    logic [31:0]       alu_b, alu_sum, alu_nor;
    logic              alu_eq;

    assign op         = opcode_e'(ir_q[OPCODE_LSB +: 3]);
    assign reg_a      = ir_q[REGA_LSB +: REG_W];
    assign reg_b      = ir_q[REGB_LSB +: REG_W];
    assign dest       = ir_q[DEST_LSB +: REG_W];
    assign offset_ext = sext_offset(ir_q[OFFSET_LSB +: OFFSET_W]);

    logic unused_ir;
    assign unused_ir = ^ir_q[31:25];

    // Memory ops add the offset; add/nor/beq use the second register operand.
    assign alu_b = (op == OpLw || op == OpSw) ? offset_ext : regBvalue;

    lc2k_alu u_alu (
        .a_i   (aluValA),
        .b_i   (alu_b),
        .sum_o (alu_sum),
        .nor_o (alu_nor),
        .eq_o  (alu_eq)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            pc_q      <= '0;
            tgt_q     <= '0;
            ir_q      <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            tgt_q     <= tgt_d;
            ir_q      <= ir_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        ir_d        = ir_q;
        alu_out_d   = alu_out_q;
        mdr_d       = mdr_q;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        read_regA   = '0;
        read_regB   = '0;
        write_reg   = '0;
        write_value = '0;
        CONTROL_ENABLE_REG_WRITE = 1'b0;
        halted      = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                read_regA = reg_a;
                read_regB = reg_b;
                pc_d      = pc_q + ADDR_W'(1);
                state_d   = (op == OpHalt) ? StHalt : StExec;
            end
            StExec: begin
                read_regA = reg_a;
                read_regB = reg_b;
                case (op)
                    OpAdd: begin
                        alu_out_d = alu_sum;
                        state_d   = StWb;
                    end
                    OpNor: begin
                        alu_out_d = alu_nor;
                        state_d   = StWb;
                    end
                    OpLw, OpSw: begin
                        alu_out_d = alu_sum;
                        state_d   = StMem;
                    end
                    OpBeq: begin
                        if (alu_eq) pc_d = pc_q + offset_ext[ADDR_W-1:0];
                        state_d = StFetch;
                    end
                    OpJalr: begin
                        // Target is captured before writeback so jalr rX rX jumps to the old rX.
                        alu_out_d = 32'(pc_q);
                        tgt_d     = aluValA[ADDR_W-1:0];
                        state_d   = StWb;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMem: begin
                read_regA = reg_a;
                read_regB = reg_b;
                mem_req   = 1'b1;
                mem_addr  = alu_out_q[ADDR_W-1:0];
                mem_we    = (op == OpSw);
                mem_wdata = regBvalue;
                if (mem_ready) begin
                    if (op == OpSw) begin
                        state_d = StFetch;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                read_regA   = reg_a;
                read_regB   = reg_b;
                CONTROL_ENABLE_REG_WRITE = 1'b1;
                write_reg   = (op == OpAdd || op == OpNor) ? dest : reg_b;
                write_value = (op == OpLw) ? mdr_q : alu_out_q;
                if (op == OpJalr) pc_d = tgt_q;
                state_d = StFetch;
            end
            StHalt: halted = 1'b1;
            default: state_d = StFetch;
        endcase

        // A reset cycle must never launch a transaction or a register write.
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            CONTROL_ENABLE_REG_WRITE = 1'b0;
        end
    end

`ifdef LC2K_PERF_CNT_EN
    logic        retire;
    logic [31:0] retired_q;

    always_comb begin
        retire = 1'b0;
        unique case (state_q)
            StDecode: retire = (op == OpHalt);
            StExec:   retire = (op == OpBeq || op == OpNoop);
            StMem:    retire = (op == OpSw) && mem_ready;
            StWb:     retire = 1'b1;
            default:  retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Self-checking bench: writebacks and memory transactions are checked against scoreboards.
module tb_lc2k_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [2:0]  read_regA, read_regB, write_reg;
    logic [31:0] aluValA, regBvalue, write_value;
    logic        CONTROL_ENABLE_REG_WRITE, halted;

    typedef struct packed {
        logic [2:0]  r;
        logic [31:0] v;
    } wb_t;

    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [31:0] d;
    } txn_t;

    wb_t  exp_wb[$];
    txn_t exp_txn[$];
    wb_t  wb_e;
    txn_t txn_e;

    int n_tests = 0;
    int n_fail  = 0;
    int lat     = 0;
    int req_cnt = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] rf [0:7];
    logic [31:0] rf_init [0:7];

    always #5 clk = ~clk;

    lc2k_multicycle_ctrl #(.ADDR_W(16)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .mem_req                  (mem_req),
        .mem_we                   (mem_we),
        .mem_addr                 (mem_addr),
        .mem_wdata                (mem_wdata),
        .mem_rdata                (mem_rdata),
        .mem_ready                (mem_ready),
        .read_regA                (read_regA),
        .read_regB                (read_regB),
        .aluValA                  (aluValA),
        .regBvalue                (regBvalue),
        .write_reg                (write_reg),
        .write_value              (write_value),
        .CONTROL_ENABLE_REG_WRITE (CONTROL_ENABLE_REG_WRITE),
        .halted                   (halted)
    );

    // Memory responder: ready after `lat` wait cycles of a held request.
    assign mem_ready = mem_req && (req_cnt >= lat);
    assign mem_rdata = mem_ready ? mem[mem_addr] : 32'h0;

    always @(posedge clk) begin
        if (mem_req === 1'b1 && mem_ready === 1'b0) req_cnt <= req_cnt + 1;
        else req_cnt <= 0;
    end

    // Register file model, reloaded from rf_init while reset is held.
    assign aluValA   = rf[read_regA];
    assign regBvalue = rf[read_regB];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_init[i];
        end else if (CONTROL_ENABLE_REG_WRITE === 1'b1) begin
            rf[write_reg] <= write_value;
        end
    end

    always @(negedge clk) begin
        if (CONTROL_ENABLE_REG_WRITE === 1'b1) begin
            n_tests++;
            if (exp_wb.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: strobe with reg=%0d val=%h, none expected",
                         write_reg, write_value);
            end else begin
                wb_e = exp_wb.pop_front();
                if (write_reg !== wb_e.r || write_value !== wb_e.v) begin
                    n_fail++;
                    $display("FAIL wb_data: got reg=%0d val=%h, want reg=%0d val=%h",
                             write_reg, write_value, wb_e.r, wb_e.v);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0 && mem_req === 1'b1 && mem_ready === 1'b1) begin
            n_tests++;
            if (exp_txn.size() == 0) begin
                n_fail++;
                $display("FAIL txn_unexpected: addr=%h we=%b, none expected", mem_addr, mem_we);
            end else begin
                txn_e = exp_txn.pop_front();
                if (mem_addr !== txn_e.a || mem_we !== txn_e.we ||
                    (txn_e.we && mem_wdata !== txn_e.d)) begin
                    n_fail++;
                    $display("FAIL txn: got addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                             mem_addr, mem_we, mem_wdata, txn_e.a, txn_e.we, txn_e.d);
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        #2 reset = 1'b0;
    endtask

    task automatic set_rf(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] r3);
        for (int i = 0; i < 8; i++) rf_init[i] = 32'h0;
        rf_init[1] = r1;
        rf_init[2] = r2;
        rf_init[3] = r3;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0 || CONTROL_ENABLE_REG_WRITE !== 1'b0 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%b strobe=%b halted=%b, want 0 0 0",
                     mem_req, CONTROL_ENABLE_REG_WRITE, halted);
        end
        n_tests++;
        if (mem_addr !== 16'h0 || read_regA !== 3'd0 || write_value !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h regA=%0d wval=%h, want 0", mem_addr, read_regA,
                     write_value);
        end
    endtask

    task automatic test_add();
        int c;
        set_rf(32'd5, 32'd3, 32'd0);
        lat = 0;
        mem[0] = 32'h000A0003;
        mem[1] = 32'h01800000;
        exp_wb.push_back('{r: 3'd3, v: 32'd8});
        exp_txn.push_back('{a: 16'h0, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'h1, we: 1'b0, d: 32'h0});
        apply_reset();
        release_reset();
        for (c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 4) begin
                n_tests++;
                if (CONTROL_ENABLE_REG_WRITE !== 1'b1 || write_reg !== 3'd3 ||
                    write_value !== 32'd8) begin
                    n_fail++;
                    $display("FAIL add_cycle4: strobe=%b reg=%0d val=%h, want 1 3 8",
                             CONTROL_ENABLE_REG_WRITE, write_reg, write_value);
                end
            end
            if (c == 5) begin
                n_tests++;
                if (CONTROL_ENABLE_REG_WRITE !== 1'b0 || write_reg !== 3'd0 ||
                    write_value !== 32'd0 || mem_req !== 1'b1 || mem_addr !== 16'h1) begin
                    n_fail++;
                    $display("FAIL add_cycle5: strobe=%b reg=%0d val=%h req=%b addr=%h",
                             CONTROL_ENABLE_REG_WRITE, write_reg, write_value, mem_req, mem_addr);
                end
            end
            if (c == 6) begin
                n_tests++;
                if (halted !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt_early: halted=%b at cycle 6, want 0", halted);
                end
            end
            if (c == 7) begin
                n_tests++;
                if (halted !== 1'b1 || mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt_cycle7: halted=%b req=%b, want 1 0", halted, mem_req);
                end
            end
        end
        #1;
        n_tests++;
        if (exp_wb.size() != 0 || exp_txn.size() != 0) begin
            n_fail++;
            $display("FAIL add_left: wb=%0d txn=%0d outstanding, want 0", exp_wb.size(),
                     exp_txn.size());
        end
    endtask

    task automatic test_nor_r0();
        int c;
        set_rf(32'hFFFF0000, 32'h0000FF00, 32'h0);
        lat = 0;
        mem[0] = 32'h004A0004;
        mem[1] = 32'h00090000;
        mem[2] = 32'h01800000;
        exp_wb.push_back('{r: 3'd4, v: 32'h000000FF});
        exp_wb.push_back('{r: 3'd0, v: 32'hFFFE0000});
        for (int i = 0; i < 3; i++) exp_txn.push_back('{a: 16'(i), we: 1'b0, d: 32'h0});
        apply_reset();
        release_reset();
        c = 0;
        while (halted !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL nor_halt: halted=%b after %0d cycles, want 1", halted, c);
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0 || halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_sticky: req=%b halted=%b, want 0 1", mem_req, halted);
        end
        #1;
        n_tests++;
        if (exp_wb.size() != 0 || exp_txn.size() != 0 || rf[0] !== 32'hFFFE0000) begin
            n_fail++;
            $display("FAIL nor_left: wb=%0d txn=%0d r0=%h, want 0 0 fffe0000", exp_wb.size(),
                     exp_txn.size(), rf[0]);
        end
    endtask

    task automatic test_lw_wait();
        int c;
        set_rf(32'h0, 32'h0, 32'h0);
        lat = 2;
        mem[0]     = 32'h0081FFFF;
        mem[1]     = 32'h01800000;
        mem[16'hFFFF] = 32'h12345678;
        exp_wb.push_back('{r: 3'd1, v: 32'h12345678});
        exp_txn.push_back('{a: 16'h0, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'hFFFF, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'h1, we: 1'b0, d: 32'h0});
        apply_reset();
        release_reset();
        for (c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c >= 6 && c <= 8) begin
                n_tests++;
                if (mem_req !== 1'b1 || mem_addr !== 16'hFFFF || mem_we !== 1'b0 ||
                    CONTROL_ENABLE_REG_WRITE !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lw_hold c%0d: req=%b addr=%h we=%b strobe=%b", c, mem_req,
                             mem_addr, mem_we, CONTROL_ENABLE_REG_WRITE);
                end
            end
            if (c == 9) begin
                n_tests++;
                if (CONTROL_ENABLE_REG_WRITE !== 1'b1) begin
                    n_fail++;
                    $display("FAIL lw_wb_cycle: strobe=%b at cycle 9, want 1",
                             CONTROL_ENABLE_REG_WRITE);
                end
            end
        end
        c = 0;
        while (halted !== 1'b1 && c < 100) begin
            @(negedge clk);
            c++;
        end
        #1;
        n_tests++;
        if (halted !== 1'b1 || exp_wb.size() != 0 || exp_txn.size() != 0) begin
            n_fail++;
            $display("FAIL lw_left: halted=%b wb=%0d txn=%0d, want 1 0 0", halted,
                     exp_wb.size(), exp_txn.size());
        end
    endtask

    task automatic test_branch_jalr();
        int c;
        set_rf(32'd5, 32'hCAFE0002, 32'h20);
        lat = 0;
        mem[0]  = 32'h00C20009;
        mem[1]  = 32'h01000003;
        mem[2]  = 32'h01800000;
        mem[3]  = 32'h01800000;
        mem[4]  = 32'h01000002;
        mem[5]  = 32'h0100FFFE;
        mem[6]  = 32'h01800000;
        mem[7]  = 32'h015B0000;
        mem[32] = 32'h01010005;
        mem[33] = 32'h01C00000;
        mem[34] = 32'h01800000;
        exp_wb.push_back('{r: 3'd3, v: 32'd8});
        exp_txn.push_back('{a: 16'h0, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'h9, we: 1'b1, d: 32'hCAFE0002});
        exp_txn.push_back('{a: 16'h1, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'h5, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'h4, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'h7, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'h20, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'h21, we: 1'b0, d: 32'h0});
        exp_txn.push_back('{a: 16'h22, we: 1'b0, d: 32'h0});
        apply_reset();
        release_reset();
        c = 0;
        while (halted !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        #1;
        n_tests++;
        if (halted !== 1'b1 || rf[3] !== 32'd8) begin
            n_fail++;
            $display("FAIL br_end: halted=%b r3=%h, want 1 00000008", halted, rf[3]);
        end
        n_tests++;
        if (exp_wb.size() != 0 || exp_txn.size() != 0) begin
            n_fail++;
            $display("FAIL br_left: wb=%0d txn=%0d outstanding, want 0", exp_wb.size(),
                     exp_txn.size());
        end
    endtask

    task automatic test_reset_mid_lw();
        int c;
        set_rf(32'h0, 32'h0, 32'h0);
        lat = 4;
        mem[0] = 32'h0081FFFF;
        exp_txn.push_back('{a: 16'h0, we: 1'b0, d: 32'h0});
        apply_reset();
        release_reset();
        c = 0;
        while (!(mem_req === 1'b1 && mem_addr === 16'hFFFF) && c < 50) begin
            @(negedge clk);
            c++;
        end
        n_tests++;
        if (mem_addr !== 16'hFFFF || mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_lw_reach: addr=%h ready=%b after %0d cycles", mem_addr,
                     mem_ready, c);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem_req !== 1'b0 || CONTROL_ENABLE_REG_WRITE !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_lw_reset: req=%b strobe=%b, want 0 0", mem_req,
                     CONTROL_ENABLE_REG_WRITE);
        end
        lat = 0;
        mem[0] = 32'h01800000;
        exp_txn.push_back('{a: 16'h0, we: 1'b0, d: 32'h0});
        @(posedge clk);
        release_reset();
        @(negedge clk);
        n_tests++;
        if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0) begin
            n_fail++;
            $display("FAIL post_reset_fetch: halted=%b req=%b addr=%h, want 0 1 0000", halted,
                     mem_req, mem_addr);
        end
        c = 0;
        while (halted !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (halted !== 1'b1 || exp_wb.size() != 0 || exp_txn.size() != 0) begin
            n_fail++;
            $display("FAIL mid_lw_left: halted=%b wb=%0d txn=%0d, want 1 0 0", halted,
                     exp_wb.size(), exp_txn.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h01C00000;
        for (int i = 0; i < 8; i++) rf_init[i] = 32'h0;
        test_reset();
        test_add();
        test_nor_r0();
        test_lw_wait();
        test_branch_jalr();
        test_reset_mid_lw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
